sample_window_buffer: RTL and testbench

- Upstream feeder stage for the interpolator's middle filter.
- Accepts one signed sample per handshake and keeps a sliding window of the 8 most recent samples.
- Presents the window in parallel on out0..out7 with a registered valid strobe. The strobe drives the filter's enable.
- Handles window fill, back-pressure and line/frame restart (flush).

---
 rtl/sample_window_buffer_if.sv | 28 ++
 rtl/sample_window_buffer.sv | 69 ++++++
 tb/tb_sample_window_buffer.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_window_buffer_if.sv
// Handshake bundle for sample_window_buffer: the sample input side and the parallel window output side.
interface sample_window_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH+1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH+1:0] out0;
  logic signed [DATA_WIDTH+1:0] out1;
  logic signed [DATA_WIDTH+1:0] out2;
  logic signed [DATA_WIDTH+1:0] out3;
  logic signed [DATA_WIDTH+1:0] out4;
  logic signed [DATA_WIDTH+1:0] out5;
  logic signed [DATA_WIDTH+1:0] out6;
  logic signed [DATA_WIDTH+1:0] out7;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out7
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out7
  );
endinterface

// File: rtl/sample_window_buffer.sv
// Sliding 8-sample window feeding the interpolator's middle filter; out0 oldest, out7 newest.
// Optional macro SAMPLE_WINDOW_EDGE_REPLICATE_EN: first sample after reset/flush fills all taps.
module sample_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  sample_window_buffer_if.slave bus
);
  localparam int W  = DATA_WIDTH + 2;
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] FULL = CW'(TAPS);

  logic signed [W-1:0] taps [TAPS];
  logic [CW-1:0]       count;
  logic [CW-1:0]       base_count;
  logic [CW-1:0]       next_count;
  logic                valid_q;
  logic                ready;
  logic                accept;
  logic                replicate;

  // Flush restarts the fill, so a sample arriving with it is always taken as the first of a new window.
  assign ready      = flush || !(valid_q && !bus.out_ready);
  assign accept     = bus.in_valid && ready;
  assign base_count = flush ? '0 : count;

`ifdef SAMPLE_WINDOW_EDGE_REPLICATE_EN
  assign replicate = (base_count == '0);
`else
  assign replicate = 1'b0;
`endif

  assign next_count = replicate            ? FULL :
                      (base_count == FULL) ? FULL :
                                             base_count + CW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < TAPS - 1; i++)
        taps[i] <= replicate ? bus.in_data : taps[i+1];
      taps[TAPS-1] <= bus.in_data;
      count        <= next_count;
      valid_q      <= (next_count == FULL);
    end else if (flush) begin
      count   <= '0;
      valid_q <= 1'b0;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out0      = taps[0];
  assign bus.out1      = taps[1];
  assign bus.out2      = taps[2];
  assign bus.out3      = taps[3];
  assign bus.out4      = taps[4];
  assign bus.out5      = taps[5];
  assign bus.out6      = taps[6];
  assign bus.out7      = taps[7];
endmodule

// File: tb/tb_sample_window_buffer.sv
// Testbench for sample_window_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_sample_window_buffer;
  localparam int DW = 8;
  localparam int W  = DW + 2;

  logic clock;
  logic reset;
  logic flush;

  sample_window_buffer_if #(.DATA_WIDTH(DW)) bus ();

  sample_window_buffer #(.DATA_WIDTH(DW), .TAPS(8)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  logic signed [W-1:0] obs [8];
  assign obs[0] = bus.out0;
  assign obs[1] = bus.out1;
  assign obs[2] = bus.out2;
  assign obs[3] = bus.out3;
  assign obs[4] = bus.out4;
  assign obs[5] = bus.out5;
  assign obs[6] = bus.out6;
  assign obs[7] = bus.out7;

  int tests  = 0;
  int failed = 0;

  // Reference model: last 8 accepted samples since reset (zero-padded), fill level since restart.
  logic signed [W-1:0] hist [$];
  int fill;
  bit mvalid;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    hist.delete();
    fill   = 0;
    mvalid = 1'b0;
  endtask

  function automatic bit model_ready();
    return flush || !(mvalid && !bus.out_ready);
  endfunction

  function automatic logic signed [W-1:0] exp_tap(int i);
    int off;
    off = 8 - hist.size();
    if (i < off) return '0;
    return hist[i-off];
  endfunction

  task automatic model_edge();
    if (bus.in_valid && model_ready()) begin
      if (flush) fill = 0;
`ifdef SAMPLE_WINDOW_EDGE_REPLICATE_EN
      if (fill == 0) begin
        hist.delete();
        repeat (8) hist.push_back(bus.in_data);
        fill = 8;
      end else
`endif
      begin
        hist.push_back(bus.in_data);
        if (hist.size() > 8) void'(hist.pop_front());
        if (fill < 8) fill++;
      end
      mvalid = (fill == 8);
    end else if (flush) begin
      fill   = 0;
      mvalid = 1'b0;
    end else if (mvalid && bus.out_ready) begin
      mvalid = 1'b0;
    end
  endtask

  task automatic drive(input bit f, input bit v, input int d, input bit r);
    flush         = f;
    bus.in_valid  = v;
    bus.in_data   = W'(d);
    bus.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 1);
    model_reset();
    #12;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_valid: got %0b expected 0", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs[i] !== '0) begin
        failed++;
        $display("[TB] FAIL reset_tap%0d: got %0d expected 0", i, obs[i]);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++;
      $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic_fill();
    int vals [8] = '{121, 5, 213, 50, 30, 184, 6, 9};
    bit exp_v;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, vals[k], 1);
      tick();
`ifdef SAMPLE_WINDOW_EDGE_REPLICATE_EN
      exp_v = 1'b1;
`else
      exp_v = (k == 7);
`endif
      tests++;
      if (bus.out_valid !== exp_v) begin
        failed++;
        $display("[TB] FAIL fill_valid_s%0d: got %0b expected %0b", k, bus.out_valid, exp_v);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs[i] !== W'(vals[i])) begin
        failed++;
        $display("[TB] FAIL fill_tap%0d: got %0d expected %0d", i, obs[i], vals[i]);
      end
    end
  endtask

  task automatic test_slide();
    int vals [8] = '{5, 213, 50, 30, 184, 6, 9, -7};
    drive(0, 1, -7, 1);
    tick();
    tests++;
    if (bus.out_valid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL slide_valid: got %0b expected 1", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs[i] !== W'(vals[i])) begin
        failed++;
        $display("[TB] FAIL slide_tap%0d: got %0d expected %0d", i, obs[i], vals[i]);
      end
    end
    drive(0, 0, 0, 1);
    tick();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL slide_drop_valid: got %0b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_pressure();
    int vals [8] = '{213, 50, 30, 184, 6, 9, -7, 11};
    drive(0, 1, 11, 0);
    tick();
    tests++;
    if (bus.out_valid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL bp_setup_valid: got %0b expected 1", bus.out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 77, 0);
      #1;
      tests++;
      if (bus.in_ready !== 1'b0) begin
        failed++;
        $display("[TB] FAIL bp_in_ready_c%0d: got %0b expected 0", c, bus.in_ready);
      end
      tick();
      tests++;
      if (bus.out_valid !== 1'b1) begin
        failed++;
        $display("[TB] FAIL bp_hold_valid_c%0d: got %0b expected 1", c, bus.out_valid);
      end
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (obs[i] !== W'(vals[i])) begin
          failed++;
          $display("[TB] FAIL bp_hold_tap%0d_c%0d: got %0d expected %0d", i, c, obs[i], vals[i]);
        end
      end
    end
    drive(0, 1, 77, 1);
    tick();
    tests++;
    if (obs[7] !== W'(77) || obs[6] !== W'(11) || obs[0] !== W'(50)) begin
      failed++;
      $display("[TB] FAIL bp_release_taps: got out0=%0d out6=%0d out7=%0d expected 50 11 77",
               obs[0], obs[6], obs[7]);
    end
    drive(0, 0, 0, 1);
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || obs[7] !== W'(77) || obs[6] !== W'(11)) begin
      failed++;
      $display("[TB] FAIL bp_accept_once: got valid=%0b out6=%0d out7=%0d expected 0 11 77",
               bus.out_valid, obs[6], obs[7]);
    end
  endtask

  task automatic test_flush_collision();
    bit exp_v;
    drive(0, 1, 3, 0);
    tick();
    drive(1, 1, 40, 0);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++;
      $display("[TB] FAIL flush_in_ready: got %0b expected 1", bus.in_ready);
    end
    tick();
`ifdef SAMPLE_WINDOW_EDGE_REPLICATE_EN
    tests++;
    if (bus.out_valid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL flush_rep_valid: got %0b expected 1", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs[i] !== W'(40)) begin
        failed++;
        $display("[TB] FAIL flush_rep_tap%0d: got %0d expected 40", i, obs[i]);
      end
    end
`else
    tests++;
    if (bus.out_valid !== 1'b0 || obs[7] !== W'(40) || obs[6] !== W'(3)) begin
      failed++;
      $display("[TB] FAIL flush_collision: got valid=%0b out6=%0d out7=%0d expected 0 3 40",
               bus.out_valid, obs[6], obs[7]);
    end
`endif
    for (int k = 0; k < 7; k++) begin
      drive(0, 1, 60 + k, 1);
      tick();
`ifdef SAMPLE_WINDOW_EDGE_REPLICATE_EN
      exp_v = 1'b1;
`else
      exp_v = (k == 6);
`endif
      tests++;
      if (bus.out_valid !== exp_v) begin
        failed++;
        $display("[TB] FAIL refill_valid_s%0d: got %0b expected %0b", k, bus.out_valid, exp_v);
      end
    end
    tests++;
    if (obs[0] !== W'(40) || obs[7] !== W'(66)) begin
      failed++;
      $display("[TB] FAIL refill_window: got out0=%0d out7=%0d expected 40 66", obs[0], obs[7]);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL async_reset_valid: got %0b expected 0", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs[i] !== '0) begin
        failed++;
        $display("[TB] FAIL async_reset_tap%0d: got %0d expected 0", i, obs[i]);
      end
    end
    model_reset();
    drive(0, 0, 0, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

`ifdef SAMPLE_WINDOW_EDGE_REPLICATE_EN
  task automatic test_replicate();
    drive(1, 0, 0, 1);
    tick();
    drive(0, 1, 100, 1);
    tick();
    tests++;
    if (bus.out_valid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL replicate_valid: got %0b expected 1", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs[i] !== W'(100)) begin
        failed++;
        $display("[TB] FAIL replicate_tap%0d: got %0d expected 100", i, obs[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic signed [W-1:0] e;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
            int'($urandom_range(0, 1023)) - 512, $urandom_range(0, 9) < 6);
      #1;
      tests++;
      if (bus.in_ready !== model_ready()) begin
        failed++;
        $display("[TB] FAIL rand_in_ready_c%0d: got %0b expected %0b", c, bus.in_ready, model_ready());
      end
      tick();
      tests++;
      if (bus.out_valid !== mvalid) begin
        failed++;
        $display("[TB] FAIL rand_valid_c%0d: got %0b expected %0b", c, bus.out_valid, mvalid);
      end
      for (int i = 0; i < 8; i++) begin
        e = exp_tap(i);
        tests++;
        if (obs[i] !== e) begin
          failed++;
          $display("[TB] FAIL rand_tap%0d_c%0d: got %0d expected %0d", i, c, obs[i], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_slide();
    test_back_pressure();
    test_flush_collision();
    test_async_reset();
`ifdef SAMPLE_WINDOW_EDGE_REPLICATE_EN
    test_replicate();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
